button_debouncer: RTL and testbench

Converts a raw, bouncy, asynchronous push-button level into a clean debounced level and single-cycle event pulses. It is the producer of the `trigger` input used by the team's counter blocks. It replaces direct wiring of a board button to a counter clock with a synchronous, one-pulse-per-press strobe, with optional auto-repeat while the button is held.

---
 rtl/debounce_pkg.sv | 24 ++
 rtl/sync_2ff.sv | 35 +++
 rtl/button_debouncer.sv | 176 +++++++++++++++++
 tb/tb_button_debouncer.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/debounce_pkg.sv
// Shared types and width helpers for the push-button debouncer.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package debounce_pkg;

    // Debounce FSM: two stable levels, each with a "candidate" state that
    // counts consecutive agreeing samples before the level is accepted.
    typedef enum logic [1:0] {
        ST_IDLE         = 2'd0,
        ST_PRESS_WAIT   = 2'd1,
        ST_HELD         = 2'd2,
        ST_RELEASE_WAIT = 2'd3
    } db_state_e;

    function automatic int max_of(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    // Bits needed to hold values 0..max_val; never narrower than 1 bit.
    function automatic int cnt_width(input int max_val);
        return (max_val < 1) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous level input.
// Latency: 2 clk cycles from first sampling edge to q.
// Backpressure: none; a level is simply tracked.
module sync_2ff (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic meta_q;
    logic meta_d;
    logic sync_q;
    logic sync_d;

    // Next-state: shift the raw input through two stages.
    always_comb begin
        meta_d = d;
        sync_d = meta_q;
    end

    // Synchronizer registers, cleared by synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            meta_q <= meta_d;
            sync_q <= sync_d;
        end
    end

    assign q = sync_q;

endmodule

// File: rtl/button_debouncer.sv
// Debounces a raw push-button into a clean level plus press/release/repeat strobes.
// Latency: level and pulses follow a clean edge by 2 + STABLE_CYCLES cycles.
// Backpressure: none; every strobe is a single-cycle fire-and-forget pulse.
module button_debouncer
    import debounce_pkg::*;
#(
    parameter int STABLE_CYCLES = 1_000_000,
    parameter bit REPEAT_EN     = 1'b0,
    parameter int REPEAT_DELAY  = 50_000_000,
    parameter int REPEAT_PERIOD = 10_000_000
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_in,
    output logic btn_level,
    output logic press_pulse,
    output logic release_pulse,
    output logic repeat_pulse,
    output logic trigger
);

    localparam int STAB_W = cnt_width(STABLE_CYCLES);
    localparam int REP_W  = cnt_width(max_of(REPEAT_DELAY, REPEAT_PERIOD));

    // The stability counter holds the number of agreeing samples seen so far;
    // the transition is taken on the sample that would make it STABLE_CYCLES,
    // so it never actually reaches that value.
    localparam logic [STAB_W-1:0] STAB_ONE  = STAB_W'(1);
    localparam logic [STAB_W-1:0] STAB_LAST = STAB_W'(STABLE_CYCLES - 1);

    // The repeat counter counts down to 1; zero means "not armed".
    localparam logic [REP_W-1:0] REP_ONE      = REP_W'(1);
    localparam logic [REP_W-1:0] REP_LOAD_DLY = REP_W'(REPEAT_DELAY);
    localparam logic [REP_W-1:0] REP_LOAD_PER = REP_W'(REPEAT_PERIOD);

    // Elaboration-time parameter legality.
    if (STABLE_CYCLES < 2) begin : g_bad_stable
        $error("button_debouncer: STABLE_CYCLES must be >= 2");
    end
    if (REPEAT_DELAY < 1) begin : g_bad_delay
        $error("button_debouncer: REPEAT_DELAY must be >= 1");
    end
    if (REPEAT_PERIOD < 1) begin : g_bad_period
        $error("button_debouncer: REPEAT_PERIOD must be >= 1");
    end

    logic s;

    db_state_e          state_q, state_d;
    logic [STAB_W-1:0]  stab_cnt_q, stab_cnt_d;
    logic [REP_W-1:0]   rep_cnt_q, rep_cnt_d;
    logic               level_q, level_d;
    logic               press_q, press_d;
    logic               release_q, release_d;
    logic               repeat_q, repeat_d;
    logic               trigger_q, trigger_d;

    sync_2ff u_sync (
        .clk (clk),
        .rst (rst),
        .d   (btn_in),
        .q   (s)
    );

    // Next-state, counters and strobes for the debounce FSM.
    always_comb begin
        state_d    = state_q;
        stab_cnt_d = stab_cnt_q;
        rep_cnt_d  = rep_cnt_q;
        level_d    = level_q;
        press_d    = 1'b0;
        release_d  = 1'b0;
        repeat_d   = 1'b0;

        // Auto-repeat runs while the level is high, including a pending
        // release, so a short release bounce does not disturb the cadence.
        if (REPEAT_EN && (state_q == ST_HELD || state_q == ST_RELEASE_WAIT)) begin
            if (rep_cnt_q == REP_ONE) begin
                repeat_d  = 1'b1;
                rep_cnt_d = REP_LOAD_PER;
            end else if (rep_cnt_q != '0) begin
                rep_cnt_d = rep_cnt_q - REP_ONE;
            end
        end

        unique case (state_q)
            ST_IDLE: begin
                stab_cnt_d = '0;
                rep_cnt_d  = '0;
                level_d    = 1'b0;
                if (s) begin
                    state_d    = ST_PRESS_WAIT;
                    stab_cnt_d = STAB_ONE;
                end
            end

            ST_PRESS_WAIT: begin
                if (!s) begin
                    state_d    = ST_IDLE;
                    stab_cnt_d = '0;
                end else if (stab_cnt_q == STAB_LAST) begin
                    state_d    = ST_HELD;
                    stab_cnt_d = '0;
                    level_d    = 1'b1;
                    press_d    = 1'b1;
                    rep_cnt_d  = REPEAT_EN ? REP_LOAD_DLY : '0;
                end else begin
                    stab_cnt_d = stab_cnt_q + STAB_ONE;
                end
            end

            ST_HELD: begin
                if (!s) begin
                    state_d    = ST_RELEASE_WAIT;
                    stab_cnt_d = STAB_ONE;
                end
            end

            ST_RELEASE_WAIT: begin
                if (s) begin
                    state_d    = ST_HELD;
                    stab_cnt_d = '0;
                end else if (stab_cnt_q == STAB_LAST) begin
                    // Release wins over a repeat falling due in this cycle.
                    state_d    = ST_IDLE;
                    stab_cnt_d = '0;
                    level_d    = 1'b0;
                    release_d  = 1'b1;
                    repeat_d   = 1'b0;
                    rep_cnt_d  = '0;
                end else begin
                    stab_cnt_d = stab_cnt_q + STAB_ONE;
                end
            end

            default: begin
                state_d    = ST_IDLE;
                stab_cnt_d = '0;
                rep_cnt_d  = '0;
                level_d    = 1'b0;
            end
        endcase

        trigger_d = press_d | repeat_d;
    end

    // State, counter and output registers; reset drops any pending transition.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            stab_cnt_q <= '0;
            rep_cnt_q  <= '0;
            level_q    <= 1'b0;
            press_q    <= 1'b0;
            release_q  <= 1'b0;
            repeat_q   <= 1'b0;
            trigger_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            stab_cnt_q <= stab_cnt_d;
            rep_cnt_q  <= rep_cnt_d;
            level_q    <= level_d;
            press_q    <= press_d;
            release_q  <= release_d;
            repeat_q   <= repeat_d;
            trigger_q  <= trigger_d;
        end
    end

    assign btn_level     = level_q;
    assign press_pulse   = press_q;
    assign release_pulse = release_q;
    assign repeat_pulse  = repeat_q;
    assign trigger       = trigger_q;

endmodule

// File: tb/tb_button_debouncer.sv
// Scoreboard bench for button_debouncer: one instance without and one with auto-repeat.
// Expected events are derived from the documented latencies when stimulus is driven.
// Outputs are sampled on the falling clock edge.
module tb_button_debouncer;

    localparam int S   = 4;
    localparam int D   = 10;
    localparam int PER = 5;
    localparam int LAT = S + 2;   // drive-cycle to observed-pulse cycle

    // Event vector: {btn_level, trigger, repeat, release, press}
    localparam logic [4:0] EV_PRESS   = 5'b11001;
    localparam logic [4:0] EV_REPEAT  = 5'b11100;
    localparam logic [4:0] EV_RELEASE = 5'b00010;

    typedef struct {
        int         cyc;
        logic [4:0] vec;
    } ev_t;

    logic clk = 1'b0;
    logic rst;
    logic btn_in;
    int   cyc = 0;

    logic lvl0, press0, rel0, rep0, trig0;
    logic lvl1, press1, rel1, rep1, trig1;

    ev_t exp_q0[$];
    ev_t exp_q1[$];

    int checks   = 0;
    int failures = 0;

    logic mon_en    = 1'b0;
    logic prev_lvl0 = 1'b0;
    logic prev_lvl1 = 1'b0;
    int   trig_tot0 = 0;
    int   trig_tot1 = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    button_debouncer #(
        .STABLE_CYCLES (S),
        .REPEAT_EN     (1'b0),
        .REPEAT_DELAY  (D),
        .REPEAT_PERIOD (PER)
    ) dut0 (
        .clk           (clk),
        .rst           (rst),
        .btn_in        (btn_in),
        .btn_level     (lvl0),
        .press_pulse   (press0),
        .release_pulse (rel0),
        .repeat_pulse  (rep0),
        .trigger       (trig0)
    );

    button_debouncer #(
        .STABLE_CYCLES (S),
        .REPEAT_EN     (1'b1),
        .REPEAT_DELAY  (D),
        .REPEAT_PERIOD (PER)
    ) dut1 (
        .clk           (clk),
        .rst           (rst),
        .btn_in        (btn_in),
        .btn_level     (lvl1),
        .press_pulse   (press1),
        .release_pulse (rel1),
        .repeat_pulse  (rep1),
        .trigger       (trig1)
    );

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d (cyc %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic push_ev(input int d, input int c, input logic [4:0] v);
        ev_t e;
        e.cyc = c;
        e.vec = v;
        if (d == 0) exp_q0.push_back(e);
        else        exp_q1.push_back(e);
    endtask

    // Clean press whose final rise is driven at rise_c and release driven at fall_c.
    task automatic expect_hold(input int rise_c, input int fall_c);
        int p;
        int r;
        int t;
        p = rise_c + LAT;
        r = fall_c + LAT;
        push_ev(0, p, EV_PRESS);
        push_ev(1, p, EV_PRESS);
        t = p + D;
        while (t < r) begin
            push_ev(1, t, EV_REPEAT);
            t += PER;
        end
        push_ev(0, r, EV_RELEASE);
        push_ev(1, r, EV_RELEASE);
    endtask

    task automatic score(input int d, input logic [4:0] v);
        ev_t  e;
        int   n;
        n = (d == 0) ? exp_q0.size() : exp_q1.size();
        if (n == 0) begin
            check_eq($sformatf("dut%0d_unexpected_event_vec%0b", d, v), 32'(n), 32'd1);
        end else begin
            e = (d == 0) ? exp_q0.pop_front() : exp_q1.pop_front();
            check_eq($sformatf("dut%0d_event_cycle", d), 32'(cyc), 32'(e.cyc));
            check_eq($sformatf("dut%0d_event_vec", d), 32'(v), 32'(e.vec));
        end
    endtask

    // Monitor: any strobe or level change is an event to be matched.
    always @(negedge clk) begin
        logic [4:0] v0;
        logic [4:0] v1;
        if (mon_en) begin
            v0 = {lvl0, trig0, rep0, rel0, press0};
            v1 = {lvl1, trig1, rep1, rel1, press1};
            if (v0[3:0] != 4'b0 || v0[4] != prev_lvl0) score(0, v0);
            if (v1[3:0] != 4'b0 || v1[4] != prev_lvl1) score(1, v1);
            prev_lvl0 = v0[4];
            prev_lvl1 = v1[4];
            if (trig0) trig_tot0++;
            if (trig1) trig_tot1++;
        end
    end

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic scenario_end(input string tag, input int base0, input int base1,
                                input int exp_t0, input int exp_t1);
        check_eq({tag, "_pending_dut0"}, 32'(exp_q0.size()), 32'd0);
        check_eq({tag, "_pending_dut1"}, 32'(exp_q1.size()), 32'd0);
        check_eq({tag, "_trigger_count_dut0"}, 32'(trig_tot0 - base0), 32'(exp_t0));
        check_eq({tag, "_trigger_count_dut1"}, 32'(trig_tot1 - base1), 32'(exp_t1));
        exp_q0.delete();
        exp_q1.delete();
    endtask

    initial begin
        int c;
        int r;
        int b0;
        int b1;
        logic [0:5] pat;

        rst    = 1'b1;
        btn_in = 1'b0;
        step(3);
        check_eq("reset_outputs_dut0", 32'({lvl0, trig0, rep0, rel0, press0}), 32'd0);
        check_eq("reset_outputs_dut1", 32'({lvl1, trig1, rep1, rel1, press1}), 32'd0);
        rst    = 1'b0;
        mon_en = 1'b1;
        step(5);

        // Clean press of 20 cycles then release.
        b0 = trig_tot0; b1 = trig_tot1;
        c = cyc;
        expect_hold(c, c + 20);
        btn_in = 1'b1;
        step(10);
        check_eq("clean_level_held_dut0", 32'(lvl0), 32'd1);
        step(10);
        btn_in = 1'b0;
        step(15);
        check_eq("clean_level_after_dut0", 32'(lvl0), 32'd0);
        scenario_end("clean", b0, b1, 1, 3);

        // Bouncy press 1,0,1,1,0,1 then held.
        b0 = trig_tot0; b1 = trig_tot1;
        pat = 6'b101101;
        c = cyc;
        expect_hold(c + 5, c + 21);
        for (int i = 0; i < 6; i++) begin
            btn_in = pat[i];
            step(1);
        end
        step(15);
        btn_in = 1'b0;
        step(15);
        scenario_end("bouncy", b0, b1, 1, 3);

        // Three-cycle glitch: nothing must happen.
        b0 = trig_tot0; b1 = trig_tot1;
        btn_in = 1'b1;
        step(3);
        btn_in = 1'b0;
        step(12);
        check_eq("glitch_level_dut0", 32'(lvl0), 32'd0);
        check_eq("glitch_level_dut1", 32'(lvl1), 32'd0);
        scenario_end("glitch", b0, b1, 0, 0);

        // Long hold: release accepted exactly when a repeat would be due.
        b0 = trig_tot0; b1 = trig_tot1;
        c = cyc;
        expect_hold(c, c + 45);
        btn_in = 1'b1;
        step(45);
        btn_in = 1'b0;
        step(20);
        scenario_end("repeat", b0, b1, 1, 8);

        // Reset in the middle of a press qualification, button still held.
        b0 = trig_tot0; b1 = trig_tot1;
        btn_in = 1'b1;
        step(4);
        rst = 1'b1;
        step(1);
        check_eq("midreset_outputs_dut0", 32'({lvl0, trig0, rep0, rel0, press0}), 32'd0);
        check_eq("midreset_outputs_dut1", 32'({lvl1, trig1, rep1, rel1, press1}), 32'd0);
        step(1);
        check_eq("midreset_outputs2_dut1", 32'({lvl1, trig1, rep1, rel1, press1}), 32'd0);
        rst = 1'b0;
        r = cyc;
        expect_hold(r, r + 20);
        step(20);
        btn_in = 1'b0;
        step(15);
        scenario_end("midreset", b0, b1, 1, 3);

        // Two-cycle release bounce while held: cadence must be untouched.
        b0 = trig_tot0; b1 = trig_tot1;
        c = cyc;
        expect_hold(c, c + 30);
        btn_in = 1'b1;
        step(9);
        btn_in = 1'b0;
        step(2);
        btn_in = 1'b1;
        step(19);
        btn_in = 1'b0;
        step(15);
        scenario_end("relbounce", b0, b1, 1, 5);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
